// File: rtl/tqvp_sprite_frame_sched.sv
// Sprite-engine frame scheduler: XGA raster counters, sync/visible strobes,
// vblank-aligned shadow-to-live commit sequencing and the frame interrupt.
module tqvp_sprite_frame_sched #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        irq_en_i,
    input  logic        irq_clr_i,
    input  logic        commit_req_i,
    output logic [10:0] h_cnt_o,
    output logic [9:0]  v_cnt_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        visible_o,
    output logic        line_stb_o,
    output logic        vblank_stb_o,
    output logic        commit_stb_o,
    output logic        commit_pending_o,
    output logic [7:0]  frame_cnt_o,
    output logic        irq_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COMMIT} state_t;

    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [7:0]  frame_q, frame_d;
    logic        vblank_evt;
    logic        visible_q, hsync_q, vsync_q, line_stb_q, vblank_stb_q, irq_q, en_q;
    logic        commit_stb_q, pending_q;
    state_t      state_q;

    always_comb begin
        vblank_evt = (h_q == 11'd0) && (v_q == V_VIS);
        h_d        = h_q + 11'd1;
        v_d        = v_q;
        frame_d    = frame_q;
        if (!en_i) begin
            h_d = 11'd0;
            v_d = 10'd0;
        end else if (h_q == H_LAST) begin
            h_d = 11'd0;
            if (v_q == V_LAST) begin
                v_d     = 10'd0;
                frame_d = frame_q + 8'd1;
            end else begin
                v_d = v_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q          <= 11'd0;
            v_q          <= 10'd0;
            frame_q      <= 8'd0;
            visible_q    <= 1'b0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            line_stb_q   <= 1'b0;
            vblank_stb_q <= 1'b0;
            irq_q        <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            frame_q      <= frame_d;
            en_q         <= en_i;
            visible_q    <= en_i && (h_q < H_VIS) && (v_q < V_VIS);
            hsync_q      <= (en_i && h_q >= HS_START && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_q      <= (en_i && v_q >= VS_START && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
            // Counters park at 0 while disabled; gate so idle time is not counted as lines.
            line_stb_q   <= en_i && (h_q == 11'd0);
            vblank_stb_q <= vblank_evt;
            if (vblank_evt && irq_en_i) begin
                irq_q <= 1'b1;
            end else if (irq_clr_i) begin
                irq_q <= 1'b0;
            end
        end
    end

    // The disable path looks at the registered enable, so a falling en lands
    // its commit one clock later than a vblank-triggered commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            commit_stb_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    commit_stb_q <= 1'b0;
                    if (commit_req_i) begin
                        state_q   <= S_PENDING;
                        pending_q <= 1'b1;
                    end
                end
                S_PENDING: begin
                    if (vblank_evt || !en_q) begin
                        state_q      <= S_COMMIT;
                        commit_stb_q <= 1'b1;
                        pending_q    <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    commit_stb_q <= 1'b0;
                    if (commit_req_i) begin
                        state_q   <= S_PENDING;
                        pending_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    commit_stb_q <= 1'b0;
                    pending_q    <= 1'b0;
                end
            endcase
        end
    end

    assign h_cnt_o          = h_q;
    assign v_cnt_o          = v_q;
    assign frame_cnt_o      = frame_q;
    assign hsync_o          = hsync_q;
    assign vsync_o          = vsync_q;
    assign visible_o        = visible_q;
    assign line_stb_o       = line_stb_q;
    assign vblank_stb_o     = vblank_stb_q;
    assign commit_stb_o     = commit_stb_q;
    assign commit_pending_o = pending_q;
    assign irq_o            = irq_q;

endmodule

// File: tb/tb_tqvp_sprite_frame_sched.sv
// Bench for tqvp_sprite_frame_sched on a shrunken raster, checked every clock
// against a position-arithmetic model, plus directed scenario checks.
module tb_tqvp_sprite_frame_sched;

    localparam int HV = 40, HFP = 4, HSW = 8, HBP = 8;
    localparam int VV = 30, VFP = 3, VSW = 6, VBP = 5;
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam bit POL = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, irq_en = 1'b0, irq_clr = 1'b0, commit_req = 1'b0;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        hsync, vsync, visible, line_stb, vblank_stb, commit_stb, commit_pending, irq;
    logic [7:0]  frame_cnt;

    tqvp_sprite_frame_sched #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en), .irq_en_i(irq_en), .irq_clr_i(irq_clr),
        .commit_req_i(commit_req), .h_cnt_o(h_cnt), .v_cnt_o(v_cnt),
        .hsync_o(hsync), .vsync_o(vsync), .visible_o(visible), .line_stb_o(line_stb),
        .vblank_stb_o(vblank_stb), .commit_stb_o(commit_stb),
        .commit_pending_o(commit_pending), .frame_cnt_o(frame_cnt), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: raster position is simply the number of enabled clocks since
    // the last reset or disable, folded by the line and frame lengths.
    int m_n, m_frame;
    bit e_vis, e_hs, e_vs, e_line, e_vb, e_stb, e_pend, e_irq, m_last_en;

    function automatic int mh();
        return m_n % HT;
    endfunction

    function automatic int mv();
        return (m_n / HT) % VT;
    endfunction

    task automatic model_reset();
        m_n = 0; m_frame = 0;
        e_vis = 0; e_hs = !POL; e_vs = !POL; e_line = 0; e_vb = 0;
        e_stb = 0; e_pend = 0; e_irq = 0; m_last_en = 0;
    endtask

    task automatic model_edge();
        int h, v;
        bit vb;
        h  = mh();
        v  = mv();
        vb = (h == 0) && (v == VV);
        e_vis  = en && (h < HV) && (v < VV);
        e_hs   = (en && h >= HV + HFP && h < HV + HFP + HSW) ? POL : !POL;
        e_vs   = (en && v >= VV + VFP && v < VV + VFP + VSW) ? POL : !POL;
        e_line = en && (h == 0);
        e_vb   = vb;
        if (e_stb) begin
            e_stb  = 0;
            e_pend = commit_req;
        end else if (e_pend) begin
            if (vb || !m_last_en) begin
                e_stb  = 1;
                e_pend = 0;
            end
        end else begin
            e_pend = commit_req;
        end
        if (vb && irq_en) e_irq = 1;
        else if (irq_clr) e_irq = 0;
        if (en) begin
            if (m_n % FT == FT - 1) m_frame = (m_frame + 1) % 256;
            m_n++;
        end else begin
            m_n = 0;
        end
        m_last_en = en;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d (h=%0d v=%0d t=%0t)", tag, obs, exp, mh(), mv(), $time);
        end
    endtask

    task automatic check_all();
        chk("h_cnt", 32'(h_cnt), 32'(mh()));
        chk("v_cnt", 32'(v_cnt), 32'(mv()));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        chk("visible", 32'(visible), 32'(e_vis));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("line_stb", 32'(line_stb), 32'(e_line));
        chk("vblank_stb", 32'(vblank_stb), 32'(e_vb));
        chk("commit_stb", 32'(commit_stb), 32'(e_stb));
        chk("commit_pending", 32'(commit_pending), 32'(e_pend));
        chk("irq", 32'(irq), 32'(e_irq));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_to(input int tv, input int th);
        int k = 0;
        while (!(mv() == tv && mh() == th) && k < 2 * FT) begin
            step();
            k++;
        end
        chk("run_to_reached", 32'(mv() == tv && mh() == th), 32'd1);
    endtask

    task automatic run_count(input int n, output int line_c, output int vb_c, output int vb_idx,
                             output int hs_c, output int vs_c, output int cs_c, output int cs_vb);
        line_c = 0; vb_c = 0; vb_idx = -1; hs_c = 0; vs_c = 0; cs_c = 0; cs_vb = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (line_stb === 1'b1) line_c++;
            if (vblank_stb === 1'b1) begin vb_c++; vb_idx = k; end
            if (hsync === POL) hs_c++;
            if (vsync === POL) vs_c++;
            if (commit_stb === 1'b1) begin
                cs_c++;
                if (vblank_stb === 1'b1) cs_vb++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lc, vc, vi, hc, vsc, cc, cv;
        model_reset();
        #23;
        chk("reset_hsync", 32'(hsync), 32'(!POL));
        chk("reset_vsync", 32'(vsync), 32'(!POL));
        check_all();
        rst = 1'b0;
        en  = 1'b1;

        // One full frame from reset.
        run_count(FT, lc, vc, vi, hc, vsc, cc, cv);
        chk("frame_line_stb_count", 32'(lc), 32'(VT));
        chk("frame_vblank_count", 32'(vc), 32'd1);
        chk("frame_vblank_index", 32'(vi), 32'(VV * HT + 1));
        chk("frame_hsync_clocks", 32'(hc), 32'(VT * HSW));
        chk("frame_vsync_clocks", 32'(vsc), 32'(VSW * HT));
        chk("frame_cnt_one", 32'(frame_cnt), 32'd1);

        // Commit request mid-frame, then a merged second request.
        run_to(10, 5);
        commit_req = 1'b1; step(); commit_req = 1'b0;
        chk("commit_pending_set", 32'(commit_pending), 32'd1);
        run_to(20, 0);
        commit_req = 1'b1; step(); commit_req = 1'b0;
        chk("commit_pending_merged", 32'(commit_pending), 32'd1);
        run_count(FT - (m_n % FT), lc, vc, vi, hc, vsc, cc, cv);
        chk("commit_stb_count", 32'(cc), 32'd1);
        chk("commit_stb_at_vblank", 32'(cv), 32'd1);

        // Frame interrupt: set, set-beats-clear, irq_en=0 keeps it, clear.
        irq_en = 1'b1;
        run_to(VV, 0);
        step();
        chk("irq_set", 32'(irq), 32'd1);
        run_to(VV, 0);
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        chk("irq_set_wins", 32'(irq), 32'd1);
        irq_en = 1'b0; step();
        chk("irq_en0_keeps", 32'(irq), 32'd1);
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        chk("irq_clr", 32'(irq), 32'd0);

        // Pending commit flushed by disabling the stream.
        run_to(15, 0);
        commit_req = 1'b1; step(); commit_req = 1'b0;
        step();
        en = 1'b0; step();
        chk("en_off_stb_clk1", 32'(commit_stb), 32'd0);
        step();
        chk("en_off_stb_clk2", 32'(commit_stb), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("en_off_h", 32'(h_cnt), 32'd0);
        chk("en_off_v", 32'(v_cnt), 32'd0);
        chk("en_off_visible", 32'(visible), 32'd0);
        chk("en_off_hsync", 32'(hsync), 32'(!POL));
        en = 1'b1;

        // Async reset discards a pending commit.
        run_to(20, 0);
        commit_req = 1'b1; step(); commit_req = 1'b0;
        run_to(25, 3);
        #2 rst = 1'b1;
        #1 model_reset();
        chk("rst_pending_immediate", 32'(commit_pending), 32'd0);
        chk("rst_h_immediate", 32'(h_cnt), 32'd0);
        check_all();
        rst = 1'b0;
        run_count(FT, lc, vc, vi, hc, vsc, cc, cv);
        chk("rst_no_commit_stb", 32'(cc), 32'd0);
        chk("rst_frame_lines", 32'(lc), 32'(VT));

        // Randomized traffic against the model.
        begin
            int en_off = 0;
            for (int i = 0; i < 9000; i++) begin
                if (en_off > 0) begin
                    en = 1'b0;
                    en_off--;
                end else begin
                    en = 1'b1;
                    if ($urandom_range(0, 799) == 0) en_off = $urandom_range(1, 20);
                end
                commit_req = ($urandom_range(0, 149) == 0);
                irq_clr    = ($urandom_range(0, 399) == 0);
                if (mv() == VV && mh() == 0) begin
                    if ($urandom_range(0, 1) == 1) commit_req = 1'b1;
                    if ($urandom_range(0, 1) == 1) irq_clr = 1'b1;
                end
                if ($urandom_range(0, 1499) == 0) irq_en = ~irq_en;
                step();
            end
            commit_req = 1'b0;
            irq_clr    = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
